// File: rtl/idex_pkg.sv
// Shared types for the ID/EX pipeline register: occupancy states, width defaults and payload bundle.
// Payload fields are sized to the supported maximum; the stage zero-extends into them.
package idex_pkg;

  localparam int unsigned AddrWDef  = 32;
  localparam int unsigned DataWDef  = 32;
  localparam int unsigned RegWDef   = 5;
  localparam int unsigned InstrWDef = 32;
  localparam int unsigned CntWDef   = 16;

  localparam int unsigned AddrWMax  = 64;
  localparam int unsigned DataWMax  = 64;
  localparam int unsigned RegWMax   = 8;
  localparam int unsigned InstrWMax = 64;

  localparam logic [InstrWMax-1:0] Nop = '0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  typedef struct packed {
    logic [AddrWMax-1:0]  addr;
    logic [DataWMax-1:0]  rd1;
    logic [DataWMax-1:0]  rd2;
    logic [DataWMax-1:0]  imm;
    logic [RegWMax-1:0]   wreg;
    logic [InstrWMax-1:0] instr;
  } payload_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register built as a two-entry skid buffer with flush and a stall counter.
// Handshake outputs are flops so nothing on the input side reaches them combinationally.
module idex_stage
  import idex_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDef,
  parameter int unsigned DATA_W  = DataWDef,
  parameter int unsigned REG_W   = RegWDef,
  parameter int unsigned INSTR_W = InstrWDef,
  parameter int unsigned CNT_W   = CntWDef
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  addressin,
  input  logic [DATA_W-1:0]  regdata1in,
  input  logic [DATA_W-1:0]  regdata2in,
  input  logic [DATA_W-1:0]  signextendedin,
  input  logic [REG_W-1:0]   writeregin,
  input  logic [INSTR_W-1:0] instructionin,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  addressout,
  output logic [DATA_W-1:0]  regdata1out,
  output logic [DATA_W-1:0]  regdata2out,
  output logic [DATA_W-1:0]  signextendedout,
  output logic [REG_W-1:0]   writeregout,
  output logic [INSTR_W-1:0] instructionout,
  output logic [CNT_W-1:0]   stall_cnt
);

  state_e   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t pl_in;
  logic     out_valid_q, out_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     in_fire, out_fire;

  always_comb begin
    pl_in       = '0;
    pl_in.addr  = AddrWMax'(addressin);
    pl_in.rd1   = DataWMax'(regdata1in);
    pl_in.rd2   = DataWMax'(regdata2in);
    pl_in.imm   = DataWMax'(signextendedin);
    pl_in.wreg  = RegWMax'(writeregin);
    pl_in.instr = InstrWMax'(instructionin);
  end

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = pl_in;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = pl_in;
        end else if (in_fire) begin
          skid_d  = pl_in;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Squash wins over any handshake in the same cycle.
    if (flush) begin
      state_d      = StEmpty;
      main_d       = '0;
      main_d.instr = Nop;
      skid_d       = '0;
    end
    out_valid_d = (state_d != StEmpty);
    in_ready_d  = (state_d != StTwo);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid_q & ~out_ready),
    .count (stall_cnt)
  );

  assign in_ready        = in_ready_q;
  assign out_valid       = out_valid_q;
  assign addressout      = main_q.addr[ADDR_W-1:0];
  assign regdata1out     = main_q.rd1[DATA_W-1:0];
  assign regdata2out     = main_q.rd2[DATA_W-1:0];
  assign signextendedout = main_q.imm[DATA_W-1:0];
  assign writeregout     = main_q.wreg[REG_W-1:0];
  assign instructionout  = main_q.instr[INSTR_W-1:0];

  // Upper payload bits beyond the configured widths are always zero.
  logic unused_main;
  assign unused_main = ^main_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage (stall counter narrowed to 4 bits to reach saturation).
module tb_idex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] addressin, regdata1in, regdata2in, signextendedin, instructionin;
  logic [4:0]  writeregin;
  logic [31:0] addressout, regdata1out, regdata2out, signextendedout, instructionout;
  logic [4:0]  writeregout;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  idex_stage #(
    .CNT_W (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .addressin       (addressin),
    .regdata1in      (regdata1in),
    .regdata2in      (regdata2in),
    .signextendedin  (signextendedin),
    .writeregin      (writeregin),
    .instructionin   (instructionin),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .addressout      (addressout),
    .regdata1out     (regdata1out),
    .regdata2out     (regdata2out),
    .signextendedout (signextendedout),
    .writeregout     (writeregout),
    .instructionout  (instructionout),
    .stall_cnt       (stall_cnt)
  );

  // Every payload field is derived from the address so one number identifies an entry.
  task automatic drive(input logic [31:0] a);
    addressin      = a;
    regdata1in     = a + 32'h1000;
    regdata2in     = a + 32'h2000;
    signextendedin = ~a;
    writeregin     = a[6:2];
    instructionin  = {a[15:0], 16'h0013};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(32'h0);
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    checks++;
    if (addressout !== 32'h0 || instructionout !== 32'h0 || writeregout !== 5'h0 ||
        stall_cnt !== 4'h0) begin
      errors++;
      $display("FAIL reset_payload: addr=%h instr=%h wreg=%h cnt=%0d required all 0",
               addressout, instructionout, writeregout, stall_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] a;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(32'h10);
    for (int i = 0; i < 4; i++) begin
      step();
      a = 32'h10 + 32'(4 * i);
      checks++;
      if (out_valid !== 1'b1 || addressout !== a || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: out_valid=%b addr=%h in_ready=%b required 1/%h/1",
                 i, out_valid, addressout, in_ready, a);
      end
      checks++;
      if (instructionout !== {a[15:0], 16'h0013} || regdata2out !== a + 32'h2000 ||
          writeregout !== a[6:2] || signextendedout !== ~a) begin
        errors++;
        $display("FAIL stream_fields_%0d: instr=%h rd2=%h wreg=%h imm=%h for addr %h",
                 i, instructionout, regdata2out, writeregout, signextendedout, a);
      end
      drive(a + 32'h4);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b stall_cnt=%0d required 0/0", out_valid, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1'b1;
    drive(32'h100);
    step();
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h100 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a: out_valid=%b addr=%h in_ready=%b required 1/100/1",
               out_valid, addressout, in_ready);
    end
    drive(32'h104);
    step();
    checks++;
    if (addressout !== 32'h100 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_two: addr=%h in_ready=%b out_valid=%b required 100/0/1",
               addressout, in_ready, out_valid);
    end
    drive(32'h108);
    step();
    checks++;
    if (addressout !== 32'h100 || in_ready !== 1'b0 || stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL bp_hold: addr=%h in_ready=%b stall_cnt=%0d required 100/0/2",
               addressout, in_ready, stall_cnt);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h104 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_b: out_valid=%b addr=%h in_ready=%b required 1/104/1",
               out_valid, addressout, in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h108) begin
      errors++;
      $display("FAIL bp_c: out_valid=%b addr=%h required 1/108", out_valid, addressout);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || stall_cnt !== 4'd2) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b stall_cnt=%0d required 0/2", out_valid, stall_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1;
    drive(32'h200);
    step();
    drive(32'h204);
    step();
    checks++;
    if (in_ready !== 1'b0 || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL flush_setup: in_ready=%b stall_cnt=%0d required 0/1", in_ready, stall_cnt);
    end
    // Collide flush with a pending input and a consume in the same cycle.
    drive(32'h208);
    flush     = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || instructionout !== 32'h0 || addressout !== 32'h0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty: out_valid=%b instr=%h addr=%h in_ready=%b required 0/0/0/1",
               out_valid, instructionout, addressout, in_ready);
    end
    checks++;
    if (stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL flush_cnt: stall_cnt=%0d required 1", stall_cnt);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_nodeliver: out_valid=%b addr=%h required 0", out_valid, addressout);
    end
    in_valid = 1'b1;
    drive(32'h20C);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h20C) begin
      errors++;
      $display("FAIL flush_after: out_valid=%b addr=%h required 1/20c", out_valid, addressout);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    drive(32'h300);
    step();
    in_valid = 1'b0;
    repeat (7) step();
    checks++;
    if (stall_cnt !== 4'd7) begin
      errors++;
      $display("FAIL sat_mid: stall_cnt=%0d required 7", stall_cnt);
    end
    repeat (13) step();
    checks++;
    if (stall_cnt !== 4'd15 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_top: stall_cnt=%0d out_valid=%b required 15/1", stall_cnt, out_valid);
    end
    repeat (3) step();
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: stall_cnt=%0d required 15", stall_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1;
    drive(32'h400);
    step();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h400 || stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL areset_setup: out_valid=%b addr=%h cnt=%0d required 1/400/1",
               out_valid, addressout, stall_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || addressout !== 32'h0 ||
        instructionout !== 32'h0 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL areset_now: out_valid=%b in_ready=%b addr=%h instr=%h cnt=%0d required 0/1/0/0/0",
               out_valid, in_ready, addressout, instructionout, stall_cnt);
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    drive(32'h500);
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || addressout !== 32'h500 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_after: out_valid=%b addr=%h in_ready=%b required 1/500/1",
               out_valid, addressout, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
